ldpc_iter_ctrl: RTL and testbench
=================================

# ldpc_iter_ctrl

Iteration controller for the 7-bit bit-flipping LDPC decoder. Accepts one received word over a valid/ready handshake and runs one flip iteration per cycle on a working register. Stops early when the syndrome is zero, or gives up after `MAX_ITER` flips. Returns the word with an iteration count, a pass flag and a running failure counter; sits between the channel front-end and the output sink.

## Interface
- `MAX_ITER`, default 4: maximum flip iterations per word, legal range 0..15.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `in_valid` in 1: input word valid.
- `in_ready` out 1: controller can accept a word.
- `in_word` in 7: received word; `in_word[i-1]` = code bit i, i = 1..7.
- `out_valid` out 1: result valid.
- `out_ready` in 1: sink accepts result.
- `out_word` out 7: decoded word, same bit mapping as `in_word`.
- `out_iters` out 4: flip iterations applied to this word.
- `out_ok` out 1: 1 = final syndrome zero.
- `fail_cnt` out 16: count of words delivered with `out_ok`=0; saturates at 0xFFFF.

## Operation
- **Parity checks** (code bits): {1,2,4}, {2,3,5}, {3,4,6}, {4,5,7}, {1,5,6}, {2,6,7}, {1,3,7}.
  - Each check is a 7-bit syndrome element; the element is 1 when the XOR of its bits is 1 (check unsatisfied).
  - Every bit participates in exactly 3 checks.
- **Flip rule**: for each bit, count the unsatisfied checks containing that bit (0..3). Flip the bit if the count is ≥2. All bits are evaluated in parallel on the same syndrome.
- **FSM states**: IDLE, RUN, DONE.
  - IDLE: `in_ready`=1. On `in_valid`: load `in_word` into the working register, clear the iteration counter, go to RUN.
  - RUN: compute the syndrome of the working register.
    - Syndrome zero: go to DONE with ok=1.
    - Else if iter==MAX_ITER: go to DONE with ok=0 and increment `fail_cnt` (saturating).
    - Else: apply the flip rule, iter+=1, stay in RUN.
  - DONE: `out_valid`=1; outputs are stable. On `out_ready`: go to IDLE.
- **Output hold**: `out_word`, `out_iters` and `out_ok` are registered. They hold their last values until the next DONE.
- **No overlap**: `in_ready`=0 in RUN and DONE; a new word is not accepted in the same cycle the result is consumed.

## Timing
- **Reset values**: `in_ready`=0 during reset (1 in the first cycle after). `out_valid`=0, `out_word`=0, `out_iters`=0, `out_ok`=0, `fail_cnt`=0, state IDLE.
- **Latency**: input handshake in cycle 0 → RUN from cycle 1 → `out_valid` in cycle 2+k, where k = flips applied, k ≤ MAX_ITER.
  - Worst case is 2+MAX_ITER cycles.
  - Minimum issue interval is 3+k cycles, given an immediate `out_ready`.
- **Backpressure**: with `out_ready` low, remain in DONE indefinitely with outputs unchanged. `fail_cnt` increments once per word, not per stall cycle.
- **Reset mid-run**: `rst_n` low in any state aborts the word, which is discarded with no output. `fail_cnt` is cleared.
- **MAX_ITER=0**: a nonzero syndrome goes straight to DONE with ok=0 and iters=0.
- **Miscorrection**: converging to a wrong codeword is reported ok=1. The controller cannot detect it.

## Structure
- **Package `ldpc_pkg`**:
  - `N`=7.
  - Parity-check matrix constant `H[7][7]`.
  - Flip threshold constant `FLIP_TH`=2.
  - FSM state enum.
- **Sub-module `ldpc_flip_stage`**: combinational. Input: word. Outputs: syndrome, flipped word, `syn_zero`. Instantiated once; the controller owns all state.

## Test plan
- **Clean word**: `in_word`=0x74 (bits 3,5,6,7) → `out_valid` at cycle 2, `out_word`=0x74, `out_iters`=0, `out_ok`=1.
- **Single error**: `in_word`=0x01 → bit 1 flipped, `out_word`=0x00, `out_iters`=1, `out_ok`=1, `out_valid` at cycle 3.
- **All ones and miscorrection**:
  - 0x7F → 0x00, iters 1, ok 1.
  - 0x03 → 0x74, iters 1, ok 1 (miscorrection).
- **Failure path and counter**: MAX_ITER=0, `in_word`=0x01 → `out_word`=0x01, iters 0, ok 0, `fail_cnt`=1. A second identical word gives `fail_cnt`=2.
- **Backpressure**: `out_ready` held low 10 cycles in DONE → outputs stable, `in_ready`=0, `fail_cnt` unchanged. On release: IDLE next cycle.
- **Reset mid-run**: `rst_n` low in RUN → next cycle IDLE, `out_valid`=0, all outputs 0. A following word decodes normally.

Source files
------------

// File: rtl/ldpc_pkg.sv
// ldpc_pkg
// Shared constants and types for the 7-bit bit-flipping LDPC decoder.
//   N        : code length (7)
//   H        : parity-check matrix, H[c] is the bit mask of check c
//              (bit i-1 of a mask corresponds to code bit i)
//   FLIP_TH  : number of unsatisfied checks at which a bit is flipped
//   state_t  : iteration controller FSM states
package ldpc_pkg;

  localparam int N = 7;

  // Checks, low to high: {1,2,4} {2,3,5} {3,4,6} {4,5,7} {1,5,6} {2,6,7} {1,3,7}.
  // Listed high index first because the packed concatenation fills from the MSB.
  localparam logic [N-1:0][N-1:0] H = {
    7'h45,  // c6: bits 1,3,7
    7'h62,  // c5: bits 2,6,7
    7'h31,  // c4: bits 1,5,6
    7'h58,  // c3: bits 4,5,7
    7'h2C,  // c2: bits 3,4,6
    7'h16,  // c1: bits 2,3,5
    7'h0B   // c0: bits 1,2,4
  };

  localparam logic [2:0] FLIP_TH = 3'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ldpc_flip_stage.sv
// ldpc_flip_stage
// Purely combinational single flip iteration on a 7-bit word.
//   word     in  : current working word
//   syndrome out : one bit per check, 1 = check unsatisfied
//   flipped  out : word after applying the flip rule once
//   syn_zero out : 1 when every check is satisfied
module ldpc_flip_stage
  import ldpc_pkg::*;
(
  input  logic [N-1:0] word,
  output logic [N-1:0] syndrome,
  output logic [N-1:0] flipped,
  output logic         syn_zero
);

  logic [2:0] cnt;

  // Each syndrome element is the parity of the bits its check covers.
  always_comb begin
    syndrome = '0;
    for (int c = 0; c < N; c++) begin
      syndrome[c] = ^(word & H[c]);
    end
  end

  assign syn_zero = (syndrome == '0);

  // All bits are judged against the same syndrome, so flips never
  // influence each other within one iteration.
  always_comb begin
    flipped = word;
    cnt     = '0;
    for (int b = 0; b < N; b++) begin
      cnt = '0;
      for (int c = 0; c < N; c++) begin
        cnt = cnt + {2'b00, syndrome[c] & H[c][b]};
      end
      if (cnt >= FLIP_TH) begin
        flipped[b] = ~word[b];
      end
    end
  end

endmodule

// File: rtl/ldpc_iter_ctrl.sv
// ldpc_iter_ctrl
// Iteration controller: accepts one word, runs up to MAX_ITER flip
// iterations (one per cycle) and presents the result until consumed.
//   MAX_ITER  param : flip iteration limit per word (0..15)
//   clk       in    : clock, rising edge
//   rst_n     in    : synchronous active-low reset
//   in_valid  in    / in_ready  out : input handshake
//   in_word   in  7 : received word
//   out_valid out   / out_ready in  : output handshake
//   out_word  out 7 : decoded word
//   out_iters out 4 : flips applied to this word
//   out_ok    out   : final syndrome was zero
//   fail_cnt  out16 : saturating count of words delivered with out_ok=0
module ldpc_iter_ctrl
  import ldpc_pkg::*;
#(
  parameter int MAX_ITER = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [6:0]   in_word,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [6:0]   out_word,
  output logic [3:0]   out_iters,
  output logic         out_ok,
  output logic [15:0]  fail_cnt
);

  state_t       state;
  logic [N-1:0] work;
  logic [3:0]   iter;
  logic [N-1:0] syndrome;
  logic [N-1:0] flipped;
  logic         syn_zero;

  ldpc_flip_stage u_flip (
    .word     (work),
    .syndrome (syndrome),
    .flipped  (flipped),
    .syn_zero (syn_zero)
  );

  // Single FSM with all outputs registered. Result registers are only
  // written on entry to DONE, so they hold between words.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_word  <= '0;
      out_iters <= '0;
      out_ok    <= 1'b0;
      fail_cnt  <= '0;
      work      <= '0;
      iter      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            work     <= in_word;
            iter     <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end else begin
            in_ready <= 1'b1;
          end
        end
        RUN: begin
          if (syn_zero) begin
            out_word  <= work;
            out_iters <= iter;
            out_ok    <= 1'b1;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (iter == 4'(MAX_ITER)) begin
            out_word  <= work;
            out_iters <= iter;
            out_ok    <= 1'b0;
            out_valid <= 1'b1;
            if (fail_cnt != 16'hFFFF) begin
              fail_cnt <= fail_cnt + 16'd1;
            end
            state <= DONE;
          end else begin
            work <= flipped;
            iter <= iter + 4'd1;
          end
        end
        DONE: begin
          // Going back through IDLE keeps a new word from being taken in
          // the same cycle the result is consumed.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ldpc_iter_ctrl.sv
// tb_ldpc_iter_ctrl
// Directed bench for ldpc_iter_ctrl. Instance dut uses the default
// MAX_ITER=4; instance dut0 uses MAX_ITER=0 for the give-up path.
module tb_ldpc_iter_ctrl;

  logic        clk;
  logic        rst_n;

  logic        in_valid,  in_ready,  out_valid,  out_ready,  out_ok;
  logic [6:0]  in_word,   out_word;
  logic [3:0]  out_iters;
  logic [15:0] fail_cnt;

  logic        in_valid0, in_ready0, out_valid0, out_ready0, out_ok0;
  logic [6:0]  in_word0,  out_word0;
  logic [3:0]  out_iters0;
  logic [15:0] fail_cnt0;

  int checks   = 0;
  int failures = 0;

  ldpc_iter_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_word   (in_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_iters (out_iters),
    .out_ok    (out_ok),
    .fail_cnt  (fail_cnt)
  );

  ldpc_iter_ctrl #(.MAX_ITER(0)) dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid0),
    .in_ready  (in_ready0),
    .in_word   (in_word0),
    .out_valid (out_valid0),
    .out_ready (out_ready0),
    .out_word  (out_word0),
    .out_iters (out_iters0),
    .out_ok    (out_ok0),
    .fail_cnt  (fail_cnt0)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case a handshake never completes.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Advance one cycle and sample 1 unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      $error("[TB] %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Send one word to dut, wait for its result, check it, then consume it.
  // exp_cycle counts from the handshake cycle as cycle 0.
  task automatic applyStimulus(input string tag, input logic [6:0] word,
                               input logic [6:0] exp_word, input logic [3:0] exp_iters,
                               input logic exp_ok, input int exp_cycle);
    int cyc;
    checkOutput({tag, "_in_ready"}, 16'(in_ready), 16'd1);
    in_word  = word;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 25) begin
      tick();
      cyc++;
    end
    checkOutput({tag, "_cycle"}, 16'(cyc), 16'(exp_cycle));
    checkOutput({tag, "_word"},  16'(out_word),  16'(exp_word));
    checkOutput({tag, "_iters"}, 16'(out_iters), 16'(exp_iters));
    checkOutput({tag, "_ok"},    16'(out_ok),    16'(exp_ok));
    checkOutput({tag, "_busy"},  16'(in_ready),  16'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput({tag, "_released"}, 16'(out_valid), 16'd0);
    checkOutput({tag, "_idle"},     16'(in_ready),  16'd1);
    checkOutput({tag, "_hold"},     16'(out_word),  16'(exp_word));
  endtask

  initial begin
    int  cyc;
    logic stable;

    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_word    = '0;
    out_ready  = 1'b0;
    in_valid0  = 1'b0;
    in_word0   = '0;
    out_ready0 = 1'b0;

    // Reset state
    repeat (3) tick();
    checkOutput("rst_in_ready",  16'(in_ready),  16'd0);
    checkOutput("rst_out_valid", 16'(out_valid), 16'd0);
    checkOutput("rst_out_word",  16'(out_word),  16'd0);
    checkOutput("rst_out_iters", 16'(out_iters), 16'd0);
    checkOutput("rst_out_ok",    16'(out_ok),    16'd0);
    checkOutput("rst_fail_cnt",  fail_cnt,       16'd0);
    rst_n = 1'b1;
    tick();
    checkOutput("post_rst_in_ready", 16'(in_ready), 16'd1);

    // Decode behaviour with MAX_ITER=4
    applyStimulus("clean",    7'h74, 7'h74, 4'd0, 1'b1, 2);
    applyStimulus("single",   7'h01, 7'h00, 4'd1, 1'b1, 3);
    applyStimulus("allones",  7'h7F, 7'h00, 4'd1, 1'b1, 3);
    applyStimulus("miscorr",  7'h03, 7'h74, 4'd1, 1'b1, 3);
    checkOutput("ok_no_fail", fail_cnt, 16'd0);

    // Give-up path with MAX_ITER=0, result held under backpressure
    in_word0  = 7'h01;
    in_valid0 = 1'b1;
    tick();
    in_valid0 = 1'b0;
    cyc = 1;
    while (!out_valid0 && cyc < 25) begin
      tick();
      cyc++;
    end
    checkOutput("fail_cycle", 16'(cyc),        16'd2);
    checkOutput("fail_word",  16'(out_word0),  16'h01);
    checkOutput("fail_iters", 16'(out_iters0), 16'd0);
    checkOutput("fail_ok",    16'(out_ok0),    16'd0);
    checkOutput("fail_cnt1",  fail_cnt0,       16'd1);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid0 !== 1'b1 || out_word0 !== 7'h01 || out_iters0 !== 4'd0 ||
          out_ok0 !== 1'b0 || in_ready0 !== 1'b0 || fail_cnt0 !== 16'd1)
        stable = 1'b0;
    end
    checkOutput("bp_stable",   16'(stable), 16'd1);
    checkOutput("bp_fail_cnt", fail_cnt0,   16'd1);
    out_ready0 = 1'b1;
    tick();
    out_ready0 = 1'b0;
    checkOutput("bp_release_valid", 16'(out_valid0), 16'd0);
    checkOutput("bp_release_ready", 16'(in_ready0),  16'd1);

    in_word0  = 7'h01;
    in_valid0 = 1'b1;
    tick();
    in_valid0 = 1'b0;
    cyc = 1;
    while (!out_valid0 && cyc < 25) begin
      tick();
      cyc++;
    end
    checkOutput("fail2_cycle", 16'(cyc), 16'd2);
    checkOutput("fail_cnt2",   fail_cnt0, 16'd2);
    out_ready0 = 1'b1;
    tick();
    out_ready0 = 1'b0;

    // Reset while dut is in RUN with a word that needs a flip
    in_word  = 7'h01;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    tick();
    checkOutput("midrst_out_valid", 16'(out_valid), 16'd0);
    checkOutput("midrst_out_word",  16'(out_word),  16'd0);
    checkOutput("midrst_out_iters", 16'(out_iters), 16'd0);
    checkOutput("midrst_out_ok",    16'(out_ok),    16'd0);
    checkOutput("midrst_in_ready",  16'(in_ready),  16'd0);
    checkOutput("midrst_fail_cnt0", fail_cnt0,      16'd0);
    rst_n = 1'b1;
    repeat (4) tick();
    checkOutput("midrst_discarded", 16'(out_valid), 16'd0);
    applyStimulus("after_rst", 7'h7F, 7'h00, 4'd1, 1'b1, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
